// File: rtl/vga_pkg.sv
// Shared video timing definitions: phase encoding, counter width and the default
// 800x600@60 mode constants used by the generator and downstream delay stages.
package vga_pkg;

   localparam int unsigned CntW   = 12;
   localparam int unsigned CntMax = 4096;

   // 800x600@60, 40 MHz pixel clock
   localparam int unsigned DefHAct  = 800;
   localparam int unsigned DefHFp   = 40;
   localparam int unsigned DefHSync = 128;
   localparam int unsigned DefHBp   = 88;
   localparam int unsigned DefVAct  = 600;
   localparam int unsigned DefVFp   = 1;
   localparam int unsigned DefVSync = 4;
   localparam int unsigned DefVBp   = 23;

   typedef enum logic [1:0] {
      PhActive,
      PhFront,
      PhSync,
      PhBack
   } vga_phase_e;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing bundle between the generator (master) and the overlay/draw stages (slave).
interface vga_timing_gen_if;
   import vga_pkg::*;

   logic            en;
   logic [CntW-1:0] hcount;
   logic [CntW-1:0] vcount;
   logic            hs;
   logic            vs;
   logic            hblnk;
   logic            vblnk;
   logic            blank;
   logic            line_start;
   logic            frame_start;

   modport master (
      input  en,
      output hcount, vcount, hs, vs, hblnk, vblnk, blank, line_start, frame_start
   );

   modport slave (
      input en, hcount, vcount, hs, vs, hblnk, vblnk, blank, line_start, frame_start
   );

endinterface

// File: rtl/vga_timing_axis.sv
// One timing axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM driven by a
// phase down-counter. Sync/blank are registered from the next state to stay aligned with count.
module vga_timing_axis
   import vga_pkg::*;
#(
   parameter int unsigned ACT  = DefHAct,
   parameter int unsigned FP   = DefHFp,
   parameter int unsigned SYNC = DefHSync,
   parameter int unsigned BP   = DefHBp,
   parameter bit          POL  = 1'b1
) (
   input  logic            pclk,
   input  logic            rst,
   input  logic            i_step,
   output logic [CntW-1:0] o_count,
   output logic            o_sync,
   output logic            o_blnk,
   output logic            o_wrap
);

   localparam int unsigned Tot = ACT + FP + SYNC + BP;

   if (Tot > CntMax || ACT < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
      $error("vga_timing_axis: total exceeds counter range or a phase length is zero");
   end

   function automatic logic [CntW-1:0] phase_last(vga_phase_e ph);
      phase_last = CntW'(ACT - 1);
      case (ph)
         PhActive: phase_last = CntW'(ACT - 1);
         PhFront:  phase_last = CntW'(FP - 1);
         PhSync:   phase_last = CntW'(SYNC - 1);
         PhBack:   phase_last = CntW'(BP - 1);
      endcase
   endfunction

   vga_phase_e      r_state, w_state_nxt;
   logic [CntW-1:0] r_phase, w_phase_nxt;
   logic [CntW-1:0] r_count, w_count_nxt;
   logic            r_sync;
   logic            r_blnk;
   logic            w_wrap;

   // Last pixel of the axis is the last cycle of the back porch
   assign w_wrap = (r_state == PhBack) && (r_phase == '0);

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_count_nxt = r_count;
      if (i_step) begin
         w_count_nxt = w_wrap ? '0 : r_count + 1'b1;
         if (r_phase == '0) begin
            case (r_state)
               PhActive: w_state_nxt = PhFront;
               PhFront:  w_state_nxt = PhSync;
               PhSync:   w_state_nxt = PhBack;
               PhBack:   w_state_nxt = PhActive;
            endcase
            w_phase_nxt = phase_last(w_state_nxt);
         end else begin
            w_phase_nxt = r_phase - 1'b1;
         end
      end
   end

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_state <= PhActive;
         r_phase <= phase_last(PhActive);
         r_count <= '0;
         r_sync  <= ~POL;
         r_blnk  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_count <= w_count_nxt;
         r_sync  <= (w_state_nxt == PhSync) ? POL : ~POL;
         r_blnk  <= (w_state_nxt != PhActive);
      end
   end

   assign o_count = r_count;
   assign o_sync  = r_sync;
   assign o_blnk  = r_blnk;
   assign o_wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: horizontal and vertical axis generators plus line/frame strobes,
// all registered and aligned to the pixel named by hcount/vcount.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACT  = DefHAct,
   parameter int unsigned H_FP   = DefHFp,
   parameter int unsigned H_SYNC = DefHSync,
   parameter int unsigned H_BP   = DefHBp,
   parameter int unsigned V_ACT  = DefVAct,
   parameter int unsigned V_FP   = DefVFp,
   parameter int unsigned V_SYNC = DefVSync,
   parameter int unsigned V_BP   = DefVBp,
   parameter bit          HS_POL = 1'b1,
   parameter bit          VS_POL = 1'b1
) (
   input logic               pclk,
   input logic               rst,
   vga_timing_gen_if.master  o_vga
);

   logic [CntW-1:0] w_hcount, w_vcount;
   logic            w_hs, w_vs, w_hblnk, w_vblnk;
   logic            w_h_wrap, w_v_wrap;
   logic            w_v_step;
   logic            r_line_start, r_frame_start;

   // Vertical advances only on the edge where the line wraps
   assign w_v_step = o_vga.en & w_h_wrap;

   vga_timing_axis #(
      .ACT  (H_ACT),
      .FP   (H_FP),
      .SYNC (H_SYNC),
      .BP   (H_BP),
      .POL  (HS_POL)
   ) u_h_axis (
      .pclk    (pclk),
      .rst     (rst),
      .i_step  (o_vga.en),
      .o_count (w_hcount),
      .o_sync  (w_hs),
      .o_blnk  (w_hblnk),
      .o_wrap  (w_h_wrap)
   );

   vga_timing_axis #(
      .ACT  (V_ACT),
      .FP   (V_FP),
      .SYNC (V_SYNC),
      .BP   (V_BP),
      .POL  (VS_POL)
   ) u_v_axis (
      .pclk    (pclk),
      .rst     (rst),
      .i_step  (w_v_step),
      .o_count (w_vcount),
      .o_sync  (w_vs),
      .o_blnk  (w_vblnk),
      .o_wrap  (w_v_wrap)
   );

   always_ff @(posedge pclk) begin
      if (rst) begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= w_v_step;
         r_frame_start <= w_v_step & w_v_wrap;
      end
   end

   assign o_vga.hcount      = w_hcount;
   assign o_vga.vcount      = w_vcount;
   assign o_vga.hs          = w_hs;
   assign o_vga.vs          = w_vs;
   assign o_vga.hblnk       = w_hblnk;
   assign o_vga.vblnk       = w_vblnk;
   assign o_vga.blank       = w_hblnk | w_vblnk;
   assign o_vga.line_start  = r_line_start;
   assign o_vga.frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 instance for horizontal timing, small inverted-polarity
// instance for frame wrap, random enable and mid-frame reset.
module tb_vga_timing_gen;

   logic pclk = 1'b0;
   logic rst  = 1'b1;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 pclk = ~pclk;

   vga_timing_gen_if vga_d ();
   vga_timing_gen_if vga_s ();

   vga_timing_gen u_dut_d (
      .pclk  (pclk),
      .rst   (rst),
      .o_vga (vga_d)
   );

   // Small mode: H 8/2/3/2 (tot 15, hs 10..12), V 4/1/2/2 (tot 9, vs 5..6), active-low syncs
   vga_timing_gen #(
      .H_ACT  (8),
      .H_FP   (2),
      .H_SYNC (3),
      .H_BP   (2),
      .V_ACT  (4),
      .V_FP   (1),
      .V_SYNC (2),
      .V_BP   (2),
      .HS_POL (1'b0),
      .VS_POL (1'b0)
   ) u_dut_s (
      .pclk  (pclk),
      .rst   (rst),
      .o_vga (vga_s)
   );

   int exp_h = 0;
   int exp_v = 0;
   int n_en  = 0;
   int n_fs  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge pclk);
         #1;
      end
   endtask

   // Compare small instance against the bench position model
   task automatic chk_s(input logic exp_ls, input logic exp_fs);
      chk("s_hcount", 32'(vga_s.hcount), 32'(exp_h));
      chk("s_vcount", 32'(vga_s.vcount), 32'(exp_v));
      chk("s_hs", 32'(vga_s.hs), 32'(!(exp_h >= 10 && exp_h <= 12)));
      chk("s_vs", 32'(vga_s.vs), 32'(!(exp_v >= 5 && exp_v <= 6)));
      chk("s_vblnk", 32'(vga_s.vblnk), 32'(exp_v >= 4));
      chk("s_blank", 32'(vga_s.blank), 32'(exp_h >= 8 || exp_v >= 4));
      chk("s_line_start", 32'(vga_s.line_start), 32'(exp_ls));
      chk("s_frame_start", 32'(vga_s.frame_start), 32'(exp_fs));
   endtask

   task automatic step_s(input logic en);
      vga_s.en = en;
      tick(1);
      if (en) begin
         exp_h = (exp_h == 14) ? 0 : exp_h + 1;
         if (exp_h == 0) exp_v = (exp_v == 8) ? 0 : exp_v + 1;
         n_en++;
      end
      if (en && exp_h == 0 && exp_v == 0) n_fs++;
      chk_s(en && exp_h == 0, en && exp_h == 0 && exp_v == 0);
   endtask

   initial begin
      int  guard;
      logic en;

      // Reset held 3 cycles with en=1
      vga_d.en = 1'b1;
      vga_s.en = 1'b1;
      rst      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("rst_hcount", 32'(vga_d.hcount), 0);
         chk("rst_vcount", 32'(vga_d.vcount), 0);
         chk("rst_hs", 32'(vga_d.hs), 0);
         chk("rst_vs", 32'(vga_d.vs), 0);
         chk("rst_blank", 32'(vga_d.blank), 0);
         chk("rst_line_start", 32'(vga_d.line_start), 0);
         chk("rst_frame_start", 32'(vga_d.frame_start), 0);
         chk("rst_s_hs_idle", 32'(vga_s.hs), 1);
         chk("rst_s_vs_idle", 32'(vga_s.vs), 1);
      end
      rst      = 1'b0;
      vga_s.en = 1'b0;

      // Horizontal timing on the default mode
      tick(1);
      chk("rel_hcount", 32'(vga_d.hcount), 1);
      chk("rel_line_start", 32'(vga_d.line_start), 0);
      chk("rel_frame_start", 32'(vga_d.frame_start), 0);
      tick(798);
      chk("h799", 32'(vga_d.hcount), 799);
      chk("hblnk799", 32'(vga_d.hblnk), 0);
      tick(1);
      chk("hblnk800", 32'(vga_d.hblnk), 1);
      chk("blank800", 32'(vga_d.blank), 1);
      chk("vblnk800", 32'(vga_d.vblnk), 0);
      tick(39);
      chk("h839", 32'(vga_d.hcount), 839);
      chk("hs839", 32'(vga_d.hs), 0);
      tick(1);
      chk("hs840", 32'(vga_d.hs), 1);
      tick(127);
      chk("hs967", 32'(vga_d.hs), 1);
      tick(1);
      chk("hs968", 32'(vga_d.hs), 0);
      tick(87);
      chk("h1055", 32'(vga_d.hcount), 1055);
      chk("v_before_wrap", 32'(vga_d.vcount), 0);
      chk("ls_before_wrap", 32'(vga_d.line_start), 0);
      tick(1);
      chk("wrap_hcount", 32'(vga_d.hcount), 0);
      chk("wrap_vcount", 32'(vga_d.vcount), 1);
      chk("wrap_line_start", 32'(vga_d.line_start), 1);
      chk("wrap_frame_start", 32'(vga_d.frame_start), 0);
      chk("wrap_blank", 32'(vga_d.blank), 0);
      tick(1);
      chk("post_wrap_hcount", 32'(vga_d.hcount), 1);
      chk("post_wrap_line_start", 32'(vga_d.line_start), 0);

      // Enable low freezes everything
      vga_d.en = 1'b0;
      tick(3);
      chk("hold_hcount", 32'(vga_d.hcount), 1);
      chk("hold_vcount", 32'(vga_d.vcount), 1);
      vga_d.en = 1'b1;
      tick(899);
      chk("h900", 32'(vga_d.hcount), 900);
      chk("hs900", 32'(vga_d.hs), 1);
      vga_d.en = 1'b0;

      // Small instance was held at (0,0) since release
      chk_s(1'b0, 1'b0);

      // Random enable: at least two full frames of enabled cycles
      for (int i = 0; i < 700; i++) begin
         en = 1'(($urandom % 3) != 0);
         step_s(en);
      end
      chk("s_frame_count", 32'(n_fs), 32'(n_en / 135));

      // One clean frame with en=1 must give exactly one frame_start
      guard = 0;
      while (!(exp_h == 0 && exp_v == 0) && guard < 200) begin
         step_s(1'b1);
         guard++;
      end
      chk("s_align_timeout", 32'(guard < 200), 1);
      n_fs = 0;
      for (int i = 0; i < 135; i++) step_s(1'b1);
      chk("s_one_frame_start", 32'(n_fs), 1);

      // Walk into hs and vs active together, then reset mid-frame
      guard = 0;
      while (!(exp_h == 11 && exp_v == 5) && guard < 200) begin
         step_s(1'b1);
         guard++;
      end
      chk("s_seek_timeout", 32'(guard < 200), 1);
      chk("s_hs_active", 32'(vga_s.hs), 0);
      chk("s_vs_active", 32'(vga_s.vs), 0);
      chk("d_hs_held", 32'(vga_d.hs), 1);
      rst = 1'b1;
      tick(1);
      chk("mid_rst_s_hcount", 32'(vga_s.hcount), 0);
      chk("mid_rst_s_vcount", 32'(vga_s.vcount), 0);
      chk("mid_rst_s_hs", 32'(vga_s.hs), 1);
      chk("mid_rst_s_vs", 32'(vga_s.vs), 1);
      chk("mid_rst_s_ls", 32'(vga_s.line_start), 0);
      chk("mid_rst_d_hcount", 32'(vga_d.hcount), 0);
      chk("mid_rst_d_vcount", 32'(vga_d.vcount), 0);
      chk("mid_rst_d_hs", 32'(vga_d.hs), 0);
      chk("mid_rst_d_blank", 32'(vga_d.blank), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
